// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//
// Purpose:
//   Shares one SRAM-like memory bus between the instruction-fetch port and
//   the LSU data port. One request is accepted at a time. Its fields are
//   latched and driven onto the bus with an address/data handshake. Read data
//   and completion are then returned only to the requester that owns the
//   transaction. Simultaneous requests alternate between the two ports.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   inst_req/inst_addr          fetch request, held until inst_addr_ok
//   inst_addr_ok/inst_data_ok   one-cycle accept / read-data-valid pulses
//   inst_rdata                  fetch read data (0 unless inst_data_ok)
//   data_req/wr/wstrb/addr/wdata  LSU request, held until data_addr_ok
//   data_addr_ok/data_data_ok   one-cycle accept / completion pulses
//   data_rdata                  load read data (0 unless data_data_ok)
//   bus_req/wr/wstrb/addr/wdata request towards the bus bridge
//   bus_addr_ok/bus_data_ok     bus address accept / transaction complete
//   bus_rdata                   bus read data
//   busy                        high while a transaction is in flight

module sram_bus_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [31:0]       bus_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              lastOwner_q, lastOwner_d;
    logic              wr_q, wr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;

    logic grantData;
    logic grantInst;
    logic completing;

    // Arbitration. Grants are combinational so that the requester sees its
    // accept pulse in the same cycle. While reset is held, no grant may leak
    // out. On a tie, the port that did not win last time is favoured.
    always_comb begin
        grantData = 1'b0;
        grantInst = 1'b0;
        if (state_q == IDLE && !rst) begin
            grantData = data_req && (!inst_req || !lastOwner_q);
            grantInst = inst_req && !grantData;
        end
    end

    // Next-state logic: latch the winner's fields on a grant, then walk the
    // address and data phases of the bus handshake.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        wr_d        = wr_q;
        wstrb_d     = wstrb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (grantData) begin
                    state_d     = ADDR;
                    owner_d     = 1'b1;
                    lastOwner_d = 1'b1;
                    wr_d        = data_wr;
                    wstrb_d     = data_wstrb;
                    addr_d      = data_addr;
                    wdata_d     = data_wdata;
                end else if (grantInst) begin
                    state_d     = ADDR;
                    owner_d     = 1'b0;
                    lastOwner_d = 1'b0;
                    wr_d        = 1'b0;
                    wstrb_d     = 4'b0000;
                    addr_d      = inst_addr;
                    wdata_d     = 32'h0;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and latched request fields. Because the reset is asynchronous,
    // an in-flight transaction is dropped instantly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            lastOwner_q <= 1'b0;
            wr_q        <= 1'b0;
            wstrb_q     <= 4'b0000;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            wr_q        <= wr_d;
            wstrb_q     <= wstrb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
        end
    end

    // Completion is forwarded only in DATA. A stray bus_data_ok in any other
    // state therefore has no effect. Only the owner sees the pulse and data.
    assign completing   = (state_q == DATA) && bus_data_ok;

    assign inst_addr_ok = grantInst;
    assign data_addr_ok = grantData;
    assign inst_data_ok = completing && !owner_q;
    assign data_data_ok = completing && owner_q;
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'h0;
    assign data_rdata   = data_data_ok ? bus_rdata : 32'h0;

    assign bus_req      = (state_q == ADDR);
    assign bus_wr       = wr_q;
    assign bus_wstrb    = wstrb_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign busy         = busy_q;

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares the single SRAM-like memory bus between the instruction-fetch port and the LSU data port (the `data_ram_*` signals). It accepts one request at a time and latches its address, write enable, strobe and data. It drives the transaction onto the bus with an address/data handshake and returns read data and completion to the owning requester. It sits between the IF stage/LSU and the bus bridge, and its `busy` output feeds the pipeline stall logic.

## Interface
Parameters:
- `ADDR_W`, 32, address width of all ports.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_req`  in  1  fetch request; held until `inst_addr_ok`.
- `inst_addr`  in  ADDR_W  fetch address.
- `inst_addr_ok`  out  1  one-cycle pulse; fetch request accepted.
- `inst_data_ok`  out  1  one-cycle pulse; `inst_rdata` valid.
- `inst_rdata`  out  32  fetch read data.
- `data_req`  in  1  LSU request; held until `data_addr_ok`.
- `data_wr`  in  1  1 = store, 0 = load.
- `data_wstrb`  in  4  byte enables (the LSU `data_ram_wen`).
- `data_addr`  in  ADDR_W  LSU address.
- `data_wdata`  in  32  store data.
- `data_addr_ok`  out  1  one-cycle pulse; LSU request accepted.
- `data_data_ok`  out  1  one-cycle pulse; load data valid or store complete.
- `data_rdata`  out  32  load read data.
- `bus_req`  out  1  bus request; held until `bus_addr_ok`.
- `bus_wr`, `bus_wstrb[3:0]`, `bus_addr[ADDR_W-1:0]`, `bus_wdata[31:0]`  out  latched request fields.
- `bus_addr_ok`  in  1  bus accepted the address.
- `bus_data_ok`  in  1  bus completed the transaction.
- `bus_rdata`  in  32  bus read data.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- State machine: IDLE, ADDR, DATA. Registers: `state`, `owner` (0 = inst, 1 = data), `last_owner`, and the latched fields `wr`, `wstrb`, `addr`, `wdata`.
- IDLE:
  - If only one request is pending, grant it.
  - If both are pending, grant the requester that is not `last_owner`.
  - On a grant: pulse the owner's `*_addr_ok` combinationally in the same cycle, latch the owner's fields, set `owner` and `last_owner`, and go to ADDR.
  - Latched fields for a fetch: `wr`=0, `wstrb`=0, `wdata`=0.
- ADDR:
  - Drive `bus_req`=1 with the latched fields.
  - On `bus_addr_ok`, go to DATA.
- DATA:
  - `bus_req`=0.
  - On `bus_data_ok`: combinationally pass `bus_data_ok` to the owner's `*_data_ok` and `bus_rdata` to the owner's `*_rdata`, then go to IDLE.
- A `bus_data_ok` arriving outside DATA is ignored.
- Requests arriving while state != IDLE are not accepted. The requester keeps `req` asserted and is arbitrated on return to IDLE.
- The non-owner's `*_addr_ok`, `*_data_ok` and `*_rdata` are 0.
- Reset mid-transaction:
  - The in-flight transaction is abandoned and no `*_data_ok` is issued.
  - The bus slave shares `rst` and discards its pending transaction.

## Timing
- Reset values:
  - `state`=IDLE, `owner`=0, `last_owner`=0, so the first tie goes to data.
  - All latched fields are 0.
  - All outputs are 0, including `bus_req`, `busy`, both `*_addr_ok`, both `*_data_ok` and both `*_rdata`.
- Minimum transaction latency:
  - Cycle 0: grant (`*_addr_ok`).
  - Cycle 1: ADDR; a same-cycle `bus_addr_ok` advances to DATA.
  - Cycle 2: DATA with `bus_data_ok` (`*_data_ok`).
  - Cycle 3: IDLE, so the next grant can occur.
- Back-to-back throughput is therefore one transaction per 3 cycles at best. Each cycle of bus wait state adds one cycle.
- `bus_*` fields are stable from entry to ADDR until the cycle after `bus_addr_ok`.
- `busy` is registered: it is 0 in IDLE, and 1 in ADDR and DATA.

## Test plan
- Single load: `data_req`=1, `data_wr`=0, `data_addr`=0x8000_0010; bus gives `bus_addr_ok` in cycle 1 and `bus_data_ok` with `bus_rdata`=0xDEAD_BEEF in cycle 2.
  - Required: `data_addr_ok` in cycle 0; `bus_addr`=0x8000_0010 and `bus_wr`=0; `data_data_ok`=1 with `data_rdata`=0xDEAD_BEEF in cycle 2; `inst_data_ok`=0 throughout.
- Byte store: `data_wr`=1, `data_wstrb`=4'b0100, `data_wdata`=0x5A5A_5A5A; bus inserts 3 wait cycles before `bus_addr_ok`.
  - Required: `bus_req` held for 4 cycles with fields stable; then `data_data_ok` pulse; `busy` falls the cycle after.
- Tie arbitration: after reset, `inst_req` and `data_req` are both held.
  - Required grant order: data, inst, data, inst. Each grant is 3 cycles apart with zero-wait bus.
- Single requester repeat: `inst_req` held continuously with no data requests.
  - Required: inst is granted every transaction, i.e. the tie rule does not block a lone requester.
- Reset mid-operation: assert `rst` while in DATA.
  - Required: all outputs 0 immediately without waiting for a clock; no `*_data_ok`; after release, a fresh data request completes normally.
- Spurious `bus_data_ok` in IDLE and ADDR.
  - Required: no `*_data_ok` pulse and no state change.
